// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package subtractor_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: DIFF = A - B - BIN, with borrow out.
module full_subtractor_1bit (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic DIFF,
  output logic BOUT
);

  assign DIFF = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: one bit per cycle, LSB first, through a single 1-bit cell.
module serial_subtractor_8bit
  import subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  input  logic             START,
  output logic             BUSY,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, bout_q, done_q, busy_q;
  logic             cell_d, cell_b;

  full_subtractor_1bit u_cell (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .BIN  (brw_q),
    .DIFF (cell_d),
    .BOUT (cell_b)
  );

  // Result bits enter at the MSB so after WIDTH shifts the LSB lands at bit 0.
  assign res_d = {cell_d, res_q[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            a_q     <= A;
            b_q     <= B;
            brw_q   <= BIN;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          brw_q <= cell_b;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          // Published outputs change only here, so no partial result is ever visible.
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= cell_b;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DIFF = diff_q;
  assign BOUT = bout_q;
  assign DONE = done_q;

endmodule

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-004 Port: A  input  WIDTH  minuend; sampled only when a START is accepted.
REQ-005 Port: B  input  WIDTH  subtrahend; sampled only when a START is accepted.
REQ-006 Port: BIN  input  1  borrow-in; sampled only when a START is accepted.
REQ-007 Port: START  input  1  request a new operation.
REQ-008 Port: BUSY  output  1  high whenever state is not IDLE.
REQ-009 Port: DIFF  output  WIDTH  result of A - B - BIN, modulo 2^WIDTH.
REQ-010 Port: BOUT  output  1  final borrow-out; 1 when A < B + BIN (unsigned).
REQ-011 Port: DONE  output  1  one-cycle pulse marking DIFF/BOUT valid.

Function
REQ-012 The block SHALL compute DIFF/BOUT bit-serially, LSB first, one bit per cycle, through a single 1-bit subtractor cell (d = a^b^bin; bout = (~a&b) | (~(a^b)&bin)).
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; all outputs registered.
REQ-014 IDLE: START=1 on an edge SHALL latch A, B, BIN into shift/borrow registers, clear the bit counter, and enter SHIFT; START=0 stays IDLE.
REQ-015 SHIFT: each edge SHALL process one bit, shift the result bit in at MSB of the result register, update the borrow register, and increment the counter.
REQ-016 After WIDTH SHIFT edges the FSM SHALL enter DONE; DIFF and BOUT update on that same edge.
REQ-017 Latency: START accepted at edge k -> DONE=1 during the cycle after edge k+WIDTH, for exactly one cycle; FSM returns to IDLE at edge k+WIDTH+1.
REQ-018 START while BUSY=1 (SHIFT or DONE) SHALL be ignored; no queueing.
REQ-019 A, B, BIN changes after acceptance SHALL NOT affect the running operation.
REQ-020 DIFF and BOUT SHALL hold their last value until the next operation's DONE edge; they SHALL NOT show partial results.
REQ-021 Back-to-back: START held high SHALL be accepted again in the first IDLE cycle, giving WIDTH+2 cycles per operation.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and never wrap during an operation.

Reset
REQ-023 RST_N=0 on an edge SHALL force IDLE, BUSY=0, DONE=0, DIFF=0, BOUT=0, counter=0, regardless of state.
REQ-024 Reset mid-SHIFT or during DONE SHALL abort the operation with no DONE pulse; the first START after release starts fresh.
REQ-025 Reset SHALL take priority over START on the same edge.

Structure
REQ-026 State encoding (IDLE/SHIFT/DONE) and WIDTH default SHALL live in shared package subtractor_pkg.
REQ-027 The 1-bit cell SHALL be a separate combinational sub-module full_subtractor_1bit (ports A, B, BIN, DIFF, BOUT), instantiated once.

Verification
REQ-028 A=5, B=3, BIN=0, START at edge 0 -> DONE high after edge 8, DIFF=0x02, BOUT=0, BUSY low after edge 9.
REQ-029 A=3, B=5, BIN=0 -> DIFF=0xFE, BOUT=1; A=0x00, B=0x00, BIN=1 -> DIFF=0xFF, BOUT=1.
REQ-030 A=0xFF, B=0x0F, BIN=0 -> DIFF=0xF0, BOUT=0; then change A/B mid-SHIFT -> result unchanged.
REQ-031 Pulse START during SHIFT and during DONE -> ignored; exactly one DONE per accepted START.
REQ-032 RST_N low at SHIFT edge 4 -> outputs zero next cycle, no DONE; next START completes normally.
REQ-033 START held high for 3 operations -> DONE every 10 cycles, results match the A-B-BIN reference model.
